// File: rtl/spi_master_apb_regfile.sv
// spi_master_apb_regfile
//
// APB register file and data buffer for the SPI master core. Decodes APB
// accesses into configuration registers and one-cycle command strobes. TX and
// RX words are buffered in FIFOs of FIFO_DEPTH entries. A maskable interrupt
// is raised on FIFO thresholds and on end of transfer.
//
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/
//   PSEL/PENABLE             APB request; PADDR[6:2] selects the register
//   PRDATA/PREADY/PSLVERR    APB response
//   spi_clk_div(_valid)      clock divider and one-cycle update pulse
//   spi_status               core status, bit 0 = busy
//   spi_cmd/spi_addr/...     command, address and length configuration
//   spi_csreg                chip-select enables
//   spi_rd/wr/qrd/qwr/swrst  one-cycle command strobes
//   spi_data_tx*             TX FIFO head handshake towards the core
//   spi_data_rx*             RX FIFO push handshake from the core
//   spi_event                registered interrupt
//
// Build option:
//   SPI_APB_FIFO_STALL_EN    when defined, a TX push into a full FIFO or an RX
//                            pop from an empty FIFO waits (PREADY=0) instead of
//                            failing with PSLVERR.

module spi_master_apb_regfile #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_CS         = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int CLKDIV_WIDTH   = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [CLKDIV_WIDTH-1:0]   spi_clk_div,
    output logic                      spi_clk_div_valid,
    input  logic [31:0]               spi_status,
    output logic [31:0]               spi_cmd,
    output logic [31:0]               spi_addr,
    output logic [5:0]                spi_cmd_len,
    output logic [5:0]                spi_addr_len,
    output logic [15:0]               spi_data_len,
    output logic [15:0]               spi_dummy_rd,
    output logic [15:0]               spi_dummy_wr,
    output logic [NUM_CS-1:0]         spi_csreg,
    output logic                      spi_rd,
    output logic                      spi_wr,
    output logic                      spi_qrd,
    output logic                      spi_qwr,
    output logic                      spi_swrst,
    output logic [31:0]               spi_data_tx,
    output logic                      spi_data_tx_valid,
    input  logic                      spi_data_tx_ready,
    input  logic [31:0]               spi_data_rx,
    input  logic                      spi_data_rx_valid,
    output logic                      spi_data_rx_ready,
    output logic                      spi_event
);

    localparam int          LW    = $clog2(FIFO_DEPTH);
    localparam logic [LW:0] DEPTH = (LW + 1)'(FIFO_DEPTH);

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_CLKDIV   = 5'd1;
    localparam logic [4:0] REG_CMD      = 5'd2;
    localparam logic [4:0] REG_ADR      = 5'd3;
    localparam logic [4:0] REG_LEN      = 5'd4;
    localparam logic [4:0] REG_DUM      = 5'd5;
    localparam logic [4:0] REG_TXFIFO   = 5'd6;
    localparam logic [4:0] REG_RXFIFO   = 5'd7;
    localparam logic [4:0] REG_FIFOSTAT = 5'd8;
    localparam logic [4:0] REG_INTCFG   = 5'd9;
    localparam logic [4:0] REG_INTSTAT  = 5'd10;

    logic [4:0]    reg_idx;
    logic          access, commit, wr_ok, rd_ok;
    logic          decode_err, fifo_block, fifo_err, slv_err;
    logic          flush;
    logic          unused_addr;

    logic [31:0]   tx_mem [FIFO_DEPTH];
    logic [31:0]   rx_mem [FIFO_DEPTH];
    logic [LW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [LW:0]   tx_count, rx_count, tx_count_next, rx_count_next;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    logic [7:0]    tx_th, rx_th;
    logic          tx_en, rx_en, eot_en;
    logic [2:0]    intstat, int_set, int_clr;
    logic          busy_q;

    assign reg_idx     = PADDR[6:2];
    assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:7], PADDR[1:0]};

    assign access = PSEL & PENABLE;

    assign tx_full  = (tx_count == DEPTH);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == DEPTH);
    assign rx_empty = (rx_count == '0);

    // An access that would overflow the TX FIFO or underflow the RX FIFO.
    assign fifo_block = access & ((PWRITE & (reg_idx == REG_TXFIFO) & tx_full) |
                                  (!PWRITE & (reg_idx == REG_RXFIFO) & rx_empty));

`ifdef SPI_APB_FIFO_STALL_EN
    assign PREADY   = !fifo_block;
    assign fifo_err = 1'b0;
`else
    assign PREADY   = 1'b1;
    assign fifo_err = fifo_block;
`endif

    // Offset legality: unmapped offsets and wrong-direction FIFO accesses.
    always_comb begin
        decode_err = 1'b0;
        case (reg_idx)
            REG_CTRL, REG_CLKDIV, REG_CMD, REG_ADR, REG_LEN,
            REG_DUM, REG_INTCFG, REG_INTSTAT: decode_err = 1'b0;
            REG_TXFIFO:                       decode_err = !PWRITE;
            REG_RXFIFO, REG_FIFOSTAT:         decode_err = PWRITE;
            default:                          decode_err = 1'b1;
        endcase
    end

    assign slv_err = decode_err | fifo_err;
    assign PSLVERR = access & slv_err;

    // Erroring accesses still complete but have no side effects.
    assign commit = access & PREADY & !slv_err;
    assign wr_ok  = commit & PWRITE;
    assign rd_ok  = commit & !PWRITE;
    assign flush  = wr_ok & (reg_idx == REG_CTRL) & PWDATA[4];

    // Full/empty come from the registered counts, so a pop never makes room
    // for a push in the same cycle.
    assign tx_push = wr_ok & (reg_idx == REG_TXFIFO) & !tx_full;
    assign tx_pop  = spi_data_tx_valid & spi_data_tx_ready;
    assign rx_push = spi_data_rx_valid & spi_data_rx_ready;
    assign rx_pop  = rd_ok & (reg_idx == REG_RXFIFO) & !rx_empty;

    assign tx_count_next = tx_count + {{LW{1'b0}}, tx_push} - {{LW{1'b0}}, tx_pop};
    assign rx_count_next = rx_count + {{LW{1'b0}}, rx_push} - {{LW{1'b0}}, rx_pop};

    assign spi_data_tx       = tx_mem[tx_rptr];
    assign spi_data_tx_valid = !tx_empty;
    assign spi_data_rx_ready = !rx_full;

    // Read mux; unmapped or write-only offsets read as zero.
    always_comb begin
        PRDATA = '0;
        case (reg_idx)
            REG_CTRL:     PRDATA = spi_status;
            REG_CLKDIV:   PRDATA[CLKDIV_WIDTH-1:0] = spi_clk_div;
            REG_CMD:      PRDATA = spi_cmd;
            REG_ADR:      PRDATA = spi_addr;
            REG_LEN:      PRDATA = {spi_data_len, 2'b00, spi_addr_len, 2'b00, spi_cmd_len};
            REG_DUM:      PRDATA = {spi_dummy_wr, spi_dummy_rd};
            REG_RXFIFO:   if (!rx_empty) PRDATA = rx_mem[rx_rptr];
            REG_FIFOSTAT: begin
                PRDATA[LW:0]       = tx_count;
                PRDATA[16+LW:16]   = rx_count;
            end
            REG_INTCFG:   PRDATA = {13'd0, eot_en, rx_en, tx_en, rx_th, tx_th};
            REG_INTSTAT:  PRDATA = {29'd0, intstat};
            default:      PRDATA = '0;
        endcase
    end

    // FIFO storage carries no reset; only pointers and counts define content.
    always_ff @(posedge HCLK) begin
        if (tx_push) tx_mem[tx_wptr] <= PWDATA;
        if (rx_push) rx_mem[rx_wptr] <= spi_data_rx;
    end

    // FIFO pointers and counts; a soft reset empties both FIFOs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else if (flush) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            tx_count <= tx_count_next;
            rx_count <= rx_count_next;
        end
    end

    // Configuration registers and strobes; strobes default low every cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            spi_clk_div       <= '0;
            spi_clk_div_valid <= 1'b0;
            spi_cmd           <= '0;
            spi_addr          <= '0;
            spi_cmd_len       <= '0;
            spi_addr_len      <= '0;
            spi_data_len      <= '0;
            spi_dummy_rd      <= '0;
            spi_dummy_wr      <= '0;
            spi_csreg         <= '0;
            {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} <= '0;
            tx_th             <= '0;
            rx_th             <= '0;
            tx_en             <= 1'b0;
            rx_en             <= 1'b0;
            eot_en            <= 1'b0;
        end else begin
            spi_clk_div_valid <= 1'b0;
            {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} <= '0;
            if (wr_ok) begin
                case (reg_idx)
                    REG_CTRL: begin
                        {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} <= PWDATA[4:0];
                        spi_csreg <= PWDATA[8 +: NUM_CS];
                    end
                    REG_CLKDIV: begin
                        spi_clk_div       <= PWDATA[CLKDIV_WIDTH-1:0];
                        spi_clk_div_valid <= 1'b1;
                    end
                    REG_CMD: spi_cmd  <= PWDATA;
                    REG_ADR: spi_addr <= PWDATA;
                    REG_LEN: begin
                        spi_cmd_len  <= PWDATA[5:0];
                        spi_addr_len <= PWDATA[13:8];
                        spi_data_len <= PWDATA[31:16];
                    end
                    REG_DUM: begin
                        spi_dummy_rd <= PWDATA[15:0];
                        spi_dummy_wr <= PWDATA[31:16];
                    end
                    REG_INTCFG: begin
                        tx_th  <= PWDATA[7:0];
                        rx_th  <= PWDATA[15:8];
                        tx_en  <= PWDATA[16];
                        rx_en  <= PWDATA[17];
                        eot_en <= PWDATA[18];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Threshold conditions use the count that becomes visible at this edge,
    // so INTSTAT and FIFOSTAT agree cycle for cycle.
    always_comb begin
        int_set[0] = 32'(tx_count_next) <= 32'(tx_th);
        int_set[1] = (rx_th != 8'd0) && (32'(rx_count_next) >= 32'(rx_th));
        int_set[2] = busy_q & !spi_status[0];
        int_clr    = (wr_ok && (reg_idx == REG_INTSTAT)) ? PWDATA[2:0] : 3'b000;
    end

    // Sticky status: a coincident set beats the W1C; soft reset clears all.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            intstat   <= '0;
            busy_q    <= 1'b0;
            spi_event <= 1'b0;
        end else begin
            busy_q    <= spi_status[0];
            intstat   <= flush ? 3'b000 : ((intstat & ~int_clr) | int_set);
            spi_event <= |(intstat & {eot_en, rx_en, tx_en});
        end
    end

endmodule

// File: tb/tb_spi_master_apb_regfile.sv
// Self-checking bench for spi_master_apb_regfile with default parameters.
// A queue-based model of both FIFOs and shadow copies of the configuration
// registers provide every expected value.

module tb_spi_master_apb_regfile;

    localparam int DEPTH = 8;

    localparam logic [11:0] A_CTRL     = 12'h000;
    localparam logic [11:0] A_CLKDIV   = 12'h004;
    localparam logic [11:0] A_CMD      = 12'h008;
    localparam logic [11:0] A_ADR      = 12'h00C;
    localparam logic [11:0] A_LEN      = 12'h010;
    localparam logic [11:0] A_DUM      = 12'h014;
    localparam logic [11:0] A_TXFIFO   = 12'h018;
    localparam logic [11:0] A_RXFIFO   = 12'h01C;
    localparam logic [11:0] A_FIFOSTAT = 12'h020;
    localparam logic [11:0] A_INTCFG   = 12'h024;
    localparam logic [11:0] A_INTSTAT  = 12'h028;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  spi_clk_div;
    logic        spi_clk_div_valid;
    logic [31:0] spi_status = '0;
    logic [31:0] spi_cmd, spi_addr;
    logic [5:0]  spi_cmd_len, spi_addr_len;
    logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
    logic [3:0]  spi_csreg;
    logic        spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst;
    logic [31:0] spi_data_tx;
    logic        spi_data_tx_valid;
    logic        spi_data_tx_ready = 1'b0;
    logic [31:0] spi_data_rx = '0;
    logic        spi_data_rx_valid = 1'b0;
    logic        spi_data_rx_ready;
    logic        spi_event;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [31:0] m_cmd = '0, m_addr = '0, m_len = '0, m_dum = '0;
    logic [7:0]  m_clkdiv = '0;

    spi_master_apb_regfile dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .spi_clk_div(spi_clk_div), .spi_clk_div_valid(spi_clk_div_valid),
        .spi_status(spi_status), .spi_cmd(spi_cmd), .spi_addr(spi_addr),
        .spi_cmd_len(spi_cmd_len), .spi_addr_len(spi_addr_len), .spi_data_len(spi_data_len),
        .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr), .spi_csreg(spi_csreg),
        .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd), .spi_qwr(spi_qwr), .spi_swrst(spi_swrst),
        .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid), .spi_data_tx_ready(spi_data_tx_ready),
        .spi_data_rx(spi_data_rx), .spi_data_rx_valid(spi_data_rx_valid), .spi_data_rx_ready(spi_data_rx_ready),
        .spi_event(spi_event)
    );

    always #5 HCLK = ~HCLK;

    // One APB transfer. Returns one cycle after the committing edge, which is
    // exactly when a strobe from that write is visible.
    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic slverr, output int waits);
        int n = 0;
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        #1;
        while (!PREADY && n < 50) begin
            @(posedge HCLK); #2;
            n++;
        end
        waits = n;
        if (!PREADY) begin
            vectors++; miscompares++;
            $display("[TB] FAIL apb_timeout: addr %h still not ready after %0d cycles", addr, n);
        end
        rdata = PRDATA;
        slverr = PSLVERR;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    function automatic logic [31:0] fifostat_model();
        return (32'(rxq.size()) << 16) | 32'(txq.size());
    endfunction

    task automatic test_reset();
        logic [31:0] rd; logic err; int wt;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK); #1;
        vectors++;
        if ({spi_clk_div, spi_clk_div_valid, spi_cmd, spi_addr, spi_cmd_len, spi_addr_len, spi_data_len,
             spi_dummy_rd, spi_dummy_wr, spi_csreg, spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst, spi_event} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_outputs: some output register is nonzero during reset");
        end
        vectors++; if (spi_data_tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", spi_data_tx_valid); end
        vectors++; if (spi_data_rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %b expected 1", spi_data_rx_ready); end
        HRESETn = 1'b1;
        apb(1'b0, A_FIFOSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd !== 32'h0 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fifostat: got %h err %b expected 0 err 0", rd, err); end
    endtask

    task automatic test_regs();
        logic [31:0] rd, w; logic err; int wt;
        apb(1'b1, A_LEN, 32'h0020_0818, rd, err, wt);
        m_len = 32'h0020_0818;
        vectors++; if (spi_cmd_len !== 6'd24) begin miscompares++; $display("[TB] FAIL len_cmd: got %0d expected 24", spi_cmd_len); end
        vectors++; if (spi_addr_len !== 6'd8) begin miscompares++; $display("[TB] FAIL len_addr: got %0d expected 8", spi_addr_len); end
        vectors++; if (spi_data_len !== 16'd32) begin miscompares++; $display("[TB] FAIL len_data: got %0d expected 32", spi_data_len); end
        apb(1'b0, A_LEN, 32'h0, rd, err, wt);
        vectors++; if (rd !== 32'h0020_0818) begin miscompares++; $display("[TB] FAIL len_readback: got %h expected 00200818", rd); end
        for (int i = 0; i < 3; i++) begin
            w = $urandom; apb(1'b1, A_CLKDIV, w, rd, err, wt); m_clkdiv = w[7:0];
            vectors++; if (spi_clk_div_valid !== 1'b1 || spi_clk_div !== m_clkdiv) begin miscompares++; $display("[TB] FAIL clkdiv_pulse: got %b/%h expected 1/%h", spi_clk_div_valid, spi_clk_div, m_clkdiv); end
            @(posedge HCLK); #1;
            vectors++; if (spi_clk_div_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clkdiv_pulse_width: got %b expected 0", spi_clk_div_valid); end
            w = $urandom; apb(1'b1, A_CMD, w, rd, err, wt); m_cmd = w;
            w = $urandom; apb(1'b1, A_ADR, w, rd, err, wt); m_addr = w;
            w = $urandom; apb(1'b1, A_DUM, w, rd, err, wt); m_dum = w;
            w = $urandom; apb(1'b1, A_LEN, w, rd, err, wt); m_len = w & 32'hFFFF_3F3F;
            vectors++; if ({spi_data_len, 2'b00, spi_addr_len, 2'b00, spi_cmd_len} !== m_len) begin miscompares++; $display("[TB] FAIL len_fields: got %h/%h/%h expected word %h", spi_data_len, spi_addr_len, spi_cmd_len, m_len); end
            vectors++; if (spi_cmd !== m_cmd || spi_addr !== m_addr) begin miscompares++; $display("[TB] FAIL cmd_addr_out: got %h %h expected %h %h", spi_cmd, spi_addr, m_cmd, m_addr); end
            vectors++; if ({spi_dummy_wr, spi_dummy_rd} !== m_dum) begin miscompares++; $display("[TB] FAIL dummy_out: got %h%h expected %h", spi_dummy_wr, spi_dummy_rd, m_dum); end
            apb(1'b0, A_CLKDIV, 32'h0, rd, err, wt);
            vectors++; if (rd !== {24'h0, m_clkdiv}) begin miscompares++; $display("[TB] FAIL clkdiv_readback: got %h expected %h", rd, {24'h0, m_clkdiv}); end
            apb(1'b0, A_CMD, 32'h0, rd, err, wt);
            vectors++; if (rd !== m_cmd) begin miscompares++; $display("[TB] FAIL cmd_readback: got %h expected %h", rd, m_cmd); end
            apb(1'b0, A_DUM, 32'h0, rd, err, wt);
            vectors++; if (rd !== m_dum) begin miscompares++; $display("[TB] FAIL dum_readback: got %h expected %h", rd, m_dum); end
            apb(1'b0, A_LEN, 32'h0, rd, err, wt);
            vectors++; if (rd !== m_len) begin miscompares++; $display("[TB] FAIL len_readback_rand: got %h expected %h", rd, m_len); end
        end
        w = 32'h0001_FFFF & $urandom;
        apb(1'b1, A_INTCFG, w, rd, err, wt);
        apb(1'b0, A_INTCFG, 32'h0, rd, err, wt);
        vectors++; if (rd !== w) begin miscompares++; $display("[TB] FAIL intcfg_readback: got %h expected %h", rd, w); end
        apb(1'b1, A_INTCFG, 32'h0, rd, err, wt);
    endtask

    task automatic test_ctrl();
        logic [31:0] rd; logic err; int wt; logic [3:0] bits, cs;
        apb(1'b1, A_CTRL, 32'h0000_0301, rd, err, wt);
        vectors++; if ({spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} !== 5'b00001) begin miscompares++; $display("[TB] FAIL ctrl_rd_strobe: got %b expected 00001", {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd}); end
        vectors++; if (spi_csreg !== 4'b0011) begin miscompares++; $display("[TB] FAIL ctrl_csreg: got %b expected 0011", spi_csreg); end
        @(posedge HCLK); #1;
        vectors++; if (spi_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL ctrl_rd_width: got %b expected 0", spi_rd); end
        for (int i = 0; i < 4; i++) begin
            bits = 4'($urandom_range(0, 15));
            cs = 4'($urandom_range(0, 15));
            apb(1'b1, A_CTRL, {20'h0, cs, 4'h0, bits}, rd, err, wt);
            vectors++; if ({spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} !== {1'b0, bits[3], bits[2], bits[1], bits[0]} || spi_csreg !== cs) begin
                miscompares++; $display("[TB] FAIL ctrl_rand: got %b cs %b expected 0%b cs %b", {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd}, spi_csreg, bits, cs);
            end
            @(posedge HCLK); #1;
            vectors++; if ({spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} !== 5'b0) begin miscompares++; $display("[TB] FAIL ctrl_rand_width: got %b expected 00000", {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd}); end
        end
        spi_status = $urandom;
        apb(1'b0, A_CTRL, 32'h0, rd, err, wt);
        vectors++; if (rd !== spi_status) begin miscompares++; $display("[TB] FAIL status_read: got %h expected %h", rd, spi_status); end
        spi_status = '0;
    endtask

    task automatic test_tx_fifo();
        logic [31:0] rd, w; logic err; int wt;
        spi_data_tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom; apb(1'b1, A_TXFIFO, w, rd, err, wt); txq.push_back(w);
            vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_push_err: got %b expected 0", err); end
        end
        vectors++; if (spi_data_tx_valid !== 1'b1 || spi_data_tx !== txq[0]) begin miscompares++; $display("[TB] FAIL tx_head: got %b/%h expected 1/%h", spi_data_tx_valid, spi_data_tx, txq[0]); end
        w = $urandom;
`ifdef SPI_APB_FIFO_STALL_EN
        fork
            apb(1'b1, A_TXFIFO, w, rd, err, wt);
            begin
                repeat (4) @(posedge HCLK); #1;
                vectors++; if (spi_data_tx !== txq[0]) begin miscompares++; $display("[TB] FAIL tx_stall_head: got %h expected %h", spi_data_tx, txq[0]); end
                spi_data_tx_ready = 1'b1;
                @(posedge HCLK); #1;
                spi_data_tx_ready = 1'b0;
                void'(txq.pop_front());
            end
        join
        txq.push_back(w);
        vectors++; if (err !== 1'b0 || wt < 1) begin miscompares++; $display("[TB] FAIL tx_stall: got err %b waits %0d expected err 0 waits >=1", err, wt); end
`else
        apb(1'b1, A_TXFIFO, w, rd, err, wt);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_overflow_err: got %b expected 1", err); end
`endif
        apb(1'b0, A_FIFOSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd !== fifostat_model()) begin miscompares++; $display("[TB] FAIL tx_count_full: got %h expected %h", rd, fifostat_model()); end
        spi_data_tx_ready = 1'b1;
        while (txq.size() > 0) begin
            vectors++; if (spi_data_tx_valid !== 1'b1 || spi_data_tx !== txq[0]) begin miscompares++; $display("[TB] FAIL tx_drain: got %b/%h expected 1/%h", spi_data_tx_valid, spi_data_tx, txq[0]); end
            void'(txq.pop_front());
            @(posedge HCLK); #1;
        end
        spi_data_tx_ready = 1'b0;
        vectors++; if (spi_data_tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_empty: got %b expected 0", spi_data_tx_valid); end
    endtask

    task automatic test_rx_event();
        logic [31:0] rd, w; logic err; int wt;
        apb(1'b1, A_INTCFG, 32'h0002_0400, rd, err, wt);
        apb(1'b1, A_INTSTAT, 32'h7, rd, err, wt);
        @(posedge HCLK); #1;
        for (int i = 1; i <= 4; i++) begin
            w = 32'hA5A5_0000 + 32'(i);
            spi_data_rx = w; spi_data_rx_valid = 1'b1; rxq.push_back(w);
            @(posedge HCLK); #1;
            if (i < 4) begin
                vectors++; if (spi_event !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_event_early: got %b expected 0 after push %0d", spi_event, i); end
            end
        end
        spi_data_rx_valid = 1'b0;
        vectors++; if (spi_event !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_event_same_cycle: got %b expected 0", spi_event); end
        @(posedge HCLK); #1;
        vectors++; if (spi_event !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_event_rise: got %b expected 1", spi_event); end
        while (rxq.size() > 0) begin
            apb(1'b0, A_RXFIFO, 32'h0, rd, err, wt);
            vectors++; if (rd !== rxq[0] || err !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_pop: got %h err %b expected %h err 0", rd, err, rxq[0]); end
            void'(rxq.pop_front());
        end
        apb(1'b1, A_INTSTAT, 32'h2, rd, err, wt);
        @(posedge HCLK); #1;
        vectors++; if (spi_event !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_event_clear: got %b expected 0", spi_event); end
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom; spi_data_rx = w; spi_data_rx_valid = 1'b1; rxq.push_back(w);
            @(posedge HCLK); #1;
        end
        spi_data_rx = $urandom;
        vectors++; if (spi_data_rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_full_ready: got %b expected 0", spi_data_rx_ready); end
        @(posedge HCLK); #1;
        spi_data_rx_valid = 1'b0;
        apb(1'b0, A_FIFOSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd !== fifostat_model()) begin miscompares++; $display("[TB] FAIL rx_count_full: got %h expected %h", rd, fifostat_model()); end
        while (rxq.size() > 0) begin
            apb(1'b0, A_RXFIFO, 32'h0, rd, err, wt);
            vectors++; if (rd !== rxq[0]) begin miscompares++; $display("[TB] FAIL rx_pop_rand: got %h expected %h", rd, rxq[0]); end
            void'(rxq.pop_front());
        end
`ifndef SPI_APB_FIFO_STALL_EN
        apb(1'b0, A_RXFIFO, 32'h0, rd, err, wt);
        vectors++; if (rd !== 32'h0 || err !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_underflow: got %h err %b expected 0 err 1", rd, err); end
`endif
    endtask

    task automatic test_eot();
        logic [31:0] rd; logic err; int wt;
        apb(1'b1, A_INTCFG, 32'h0004_0000, rd, err, wt);
        apb(1'b1, A_INTSTAT, 32'h7, rd, err, wt);
        spi_status = 32'h1;
        repeat (2) @(posedge HCLK); #1;
        spi_status = 32'h0;
        repeat (2) @(posedge HCLK); #1;
        vectors++; if (spi_event !== 1'b1) begin miscompares++; $display("[TB] FAIL eot_event: got %b expected 1", spi_event); end
        apb(1'b0, A_INTSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL eot_set: got %b expected 1", rd[2]); end
        apb(1'b1, A_INTSTAT, 32'h4, rd, err, wt);
        apb(1'b0, A_INTSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL eot_w1c: got %b expected 0", rd[2]); end
        vectors++; if (spi_event !== 1'b0) begin miscompares++; $display("[TB] FAIL eot_event_clear: got %b expected 0", spi_event); end
        // W1C committing on the same edge that detects a new busy fall.
        spi_status = 32'h1;
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_INTSTAT; PWDATA = 32'h4;
        @(posedge HCLK); #1;
        PENABLE = 1'b1; spi_status = 32'h0;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb(1'b0, A_INTSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL eot_set_wins: got %b expected 1", rd[2]); end
        apb(1'b1, A_INTCFG, 32'h0, rd, err, wt);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int wt; logic [4:0] idx;
        apb(1'b0, 12'h030, 32'h0, rd, err, wt);
        vectors++; if (rd !== 32'h0 || err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_read_30: got %h err %b expected 0 err 1", rd, err); end
        for (int i = 0; i < 4; i++) begin
            idx = 5'($urandom_range(11, 31));
            apb(1'b1, {5'h0, idx, 2'b00}, $urandom, rd, err, wt);
            vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_write_unmapped: got %b expected 1 at idx %0d", err, idx); end
        end
        apb(1'b0, A_CMD, 32'h0, rd, err, wt);
        vectors++; if (rd !== m_cmd) begin miscompares++; $display("[TB] FAIL err_no_side_effect: got %h expected %h", rd, m_cmd); end
        apb(1'b1, A_FIFOSTAT, 32'hFFFF_FFFF, rd, err, wt);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_write_fifostat: got %b expected 1", err); end
        apb(1'b1, A_RXFIFO, 32'h1234_5678, rd, err, wt);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_write_rxfifo: got %b expected 1", err); end
        apb(1'b0, A_TXFIFO, 32'h0, rd, err, wt);
        vectors++; if (err !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err_read_txfifo: got %h err %b expected 0 err 1", rd, err); end
        apb(1'b0, A_FIFOSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd !== fifostat_model()) begin miscompares++; $display("[TB] FAIL err_counts: got %h expected %h", rd, fifostat_model()); end
    endtask

    task automatic test_swrst();
        logic [31:0] rd, w; logic err; int wt;
        spi_data_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = $urandom; apb(1'b1, A_TXFIFO, w, rd, err, wt); txq.push_back(w);
        end
        for (int i = 0; i < 2; i++) begin
            w = $urandom; spi_data_rx = w; spi_data_rx_valid = 1'b1; rxq.push_back(w);
            @(posedge HCLK); #1;
        end
        spi_data_rx_valid = 1'b0;
        apb(1'b0, A_FIFOSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd !== fifostat_model()) begin miscompares++; $display("[TB] FAIL swrst_before: got %h expected %h", rd, fifostat_model()); end
        apb(1'b1, A_CTRL, 32'h0000_0010, rd, err, wt);
        txq.delete(); rxq.delete();
        vectors++; if (spi_swrst !== 1'b1 || spi_data_tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL swrst_strobe: got swrst %b tx_valid %b expected 1 0", spi_swrst, spi_data_tx_valid); end
        apb(1'b0, A_FIFOSTAT, 32'h0, rd, err, wt);
        vectors++; if (rd !== fifostat_model()) begin miscompares++; $display("[TB] FAIL swrst_flush: got %h expected %h", rd, fifostat_model()); end
        apb(1'b0, A_CMD, 32'h0, rd, err, wt);
        vectors++; if (rd !== m_cmd) begin miscompares++; $display("[TB] FAIL swrst_keeps_cfg: got %h expected %h", rd, m_cmd); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_ctrl();
        test_tx_fifo();
        test_rx_event();
        test_eot();
        test_errors();
        test_swrst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_master_apb_regfile.md
# spi_master_apb_regfile

Parametrised APB register file and data buffer for the SPI master core. Decodes APB accesses into configuration registers and single-cycle command strobes. Buffers TX and RX words in internal FIFOs of configurable depth, supports a configurable number of chip selects, and raises a maskable interrupt on FIFO thresholds and end of transfer. Sits between the APB interconnect and the SPI master controller.

## Interface
- APB_ADDR_WIDTH, 12, APB address width.
- NUM_CS, 4, number of chip selects (1..8).
- FIFO_DEPTH, 8, words per TX/RX FIFO (power of 2, >=2); LW = $clog2(FIFO_DEPTH), counts are LW+1 bits.
- CLKDIV_WIDTH, 8, clock divider width (<=32).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  APB_ADDR_WIDTH  address; PADDR[6:2] selects the register.
- PWDATA  in  32  write data.
- PWRITE, PSEL, PENABLE  in  1  APB control.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer ready.
- PSLVERR  out  1  slave error.
- spi_clk_div  out  CLKDIV_WIDTH  divider.
- spi_clk_div_valid  out  1  one-cycle pulse on CLKDIV write.
- spi_status  in  32  core status; bit 0 = busy.
- spi_cmd, spi_addr  out  32  command and address words.
- spi_cmd_len, spi_addr_len  out  6  bit lengths.
- spi_data_len, spi_dummy_rd, spi_dummy_wr  out  16  lengths.
- spi_csreg  out  NUM_CS  chip-select enable.
- spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst  out  1  one-cycle strobes.
- spi_data_tx  out  32  TX FIFO head.
- spi_data_tx_valid  out  1  TX FIFO not empty.
- spi_data_tx_ready  in  1  core accepts head.
- spi_data_rx  in  32  RX word.
- spi_data_rx_valid  in  1  RX word valid.
- spi_data_rx_ready  out  1  RX FIFO not full.
- spi_event  out  1  interrupt, registered.

## Operation
- An access completes on PSEL&PENABLE&PREADY. Writes commit at that edge.
- Register map:
  - 0x00 CTRL/STATUS. Write: bits 0..4 pulse rd/wr/qrd/qwr/swrst; bits [8+:NUM_CS] load csreg. Read: spi_status.
  - 0x04 CLKDIV, read/write.
  - 0x08 CMD, read/write.
  - 0x0C ADR, read/write.
  - 0x10 LEN: [5:0] cmd_len, [13:8] addr_len, [31:16] data_len.
  - 0x14 DUM: [15:0] dummy_rd, [31:16] dummy_wr.
  - 0x18 TXFIFO, write-only push.
  - 0x1C RXFIFO, read-only pop.
  - 0x20 FIFOSTAT, read-only: [LW:0] tx count, [16+LW:16] rx count.
  - 0x24 INTCFG: [7:0] tx_th, [15:8] rx_th, [16] tx_en, [17] rx_en, [18] eot_en.
  - 0x28 INTSTAT, write-1-to-clear.
- Any other offset returns PRDATA=0 with PSLVERR=1 and no side effect. A write to a read-only offset (0x1C, 0x20) or a read of 0x18 also errors.
- TX FIFO:
  - APB push writes PWDATA.
  - Core pops on spi_data_tx_valid&spi_data_tx_ready.
- RX FIFO:
  - Core pushes on spi_data_rx_valid&spi_data_rx_ready.
  - APB pop returns the head combinationally.
- Full and empty are evaluated on the registered count. A same-cycle pop does not free space for a same-cycle APB push; simultaneous push and pop on a non-full, non-empty FIFO leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- A spi_swrst write flushes both FIFOs and clears INTSTAT at the same edge. Config registers are kept.
- INTSTAT sticky bits:
  - bit 0 sets while tx count <= tx_th.
  - bit 1 sets while rx count >= rx_th (rx_th=0 never sets).
  - bit 2 sets on busy 1->0 (registered edge detect).
  - When a set condition and a W1C hit the same bit in the same cycle, set wins.
- spi_event = |(INTSTAT & enables), registered.

## Timing
- Reset values: every output register is 0, both FIFOs empty, INTCFG=0, INTSTAT=0. spi_data_tx_valid=0 and spi_data_rx_ready=1 after reset.
- Strobes and spi_clk_div_valid are high exactly one cycle after the committing edge.
- Register reads: zero wait states. FIFO read data appears one cycle after a push.
- spi_event asserts one cycle after INTSTAT sets.
- Reset mid-transfer aborts the APB access. FIFO contents are lost.

## Configuration
- SPI_APB_FIFO_STALL_EN
  - Defined: a TXFIFO write while full, or an RXFIFO read while empty, holds PREADY=0 until the condition clears. The access then completes with PSLVERR=0.
  - Undefined: PREADY is always 1. Such accesses complete immediately with PSLVERR=1; the write is dropped, or the read returns 0 without a pop.

## Test plan
- Reset: after HRESETn low then high, all outputs are 0, spi_data_rx_ready=1, and FIFOSTAT reads 0.
- Write CTRL=0x0000_0301 -> spi_rd pulses exactly one cycle and spi_csreg=4'b0011. Write LEN=0x0020_0818 -> spi_cmd_len=24, spi_addr_len=8, spi_data_len=32, and the register reads back 0x0020_0818.
- Push 8 words with FIFO_DEPTH=8 and the core not ready, then push a 9th:
  - Stall build: PREADY stays low until one spi_data_tx_ready cycle, then the 9th word lands.
  - Non-stall build: PSLVERR=1 and count stays 8.
- Core pushes 0xA5A5_0001..0004 with rx_th=4 and rx_en=1 -> spi_event rises one cycle after the 4th push. Four RXFIFO reads return the words in order. W1C 0x2 clears spi_event.
- Drive busy 1->0 with eot_en=1 -> INTSTAT[2]=1. Apply W1C on the same cycle as a new falling edge -> the bit stays set.
- Read offset 0x30 -> PSLVERR=1, PRDATA=0. CTRL write with bit 4 set while both FIFOs hold data -> both counts are 0 on the next cycle.
